rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sequences one transaction at a time through a req/gnt/rvalid handshake toward memory.
- Returns per-requester valid pulses. The fetch-side pulse drives the pipeline's imem_valid stall input.
- Data side has priority, with a bounded-starvation guarantee for fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_STARVE, 4, maximum consecutive data grants while fetch is pending before fetch is forced (legal range ≥1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- resetn_i  in  1  reset, synchronous, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  ADDR_W  fetch address (word-aligned).
- if_valid_o  out  1  one-cycle pulse: fetch data available.
- if_rdata_o  out  DATA_W  fetch data, meaningful only while if_valid_o is high.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_be_i  in  DATA_W/8  store byte enables.
- d_valid_o  out  1  one-cycle pulse: load data available or store completed.
- d_rdata_o  out  DATA_W  load data, meaningful only while d_valid_o is high.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response (sent for reads and writes).
- mem_rdata_i  in  DATA_W  memory read data.
- busy_o  out  1  a transaction is in flight (state ≠ IDLE).

Behaviour:
- Reset (resetn_i low at a clock edge):
  - state = IDLE; starve counter = 0; owner = fetch.
  - mem_req_o, mem_we_o, if_valid_o, d_valid_o, busy_o = 0.
  - mem_addr_o, mem_wdata_o, mem_be_o = 0.
  - Reset mid-transaction abandons it; no valid pulse is ever generated for it.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise arbitrate, latch owner and payload into registers, go to REQ.
  - Fetch payload: addr = if_addr_i, we = 0, be = all ones, wdata = 0.
  - Data payload: d_we_i, d_addr_i, d_wdata_i, d_be_i.
- Arbitration, evaluated only in IDLE:
  - Data only → data. Fetch only → fetch.
  - Both requesting → data, unless starve counter == MAX_STARVE, in which case → fetch.
- Starve counter:
  - Increments, saturating at MAX_STARVE, on each data grant made while if_req_i is high.
  - Clears to 0 on each fetch grant.
  - Unchanged otherwise.
- REQ:
  - mem_req_o = 1 and the mem_* outputs present the latched payload (all registered).
  - Stay in REQ until mem_gnt_i = 1 is sampled, then go to RESP and drop mem_req_o the next cycle.
- RESP:
  - mem_req_o = 0.
  - When mem_rvalid_i = 1: pulse the owner's valid for exactly that cycle (combinational from mem_rvalid_i qualified by state and owner). Owner's rdata = mem_rdata_i. Next state = IDLE.
  - The non-owner's valid stays 0.
- Latency: with zero-wait memory (gnt in the first REQ cycle, rvalid the cycle after gnt), a request seen in IDLE at cycle N gives mem_req_o high at N+1 and valid at N+2. Back-to-back transactions start every 3 cycles.
- Requester rule: req and payload must be held until the corresponding valid pulse.
  - A request dropped after being latched does not cancel the transaction; the response pulse is still produced.
  - Payload changes after latch are ignored.
- mem_rvalid_i while in IDLE or REQ is ignored (no valid pulse, no state change).
- mem_gnt_i outside REQ is ignored.
- Simultaneous gnt and rvalid in REQ: take the gnt only; the rvalid is ignored. The memory shall not do this.
- Only one transaction is outstanding at a time; no pipelining of requests.

Test Plan:
- Reset then a lone fetch: if_req_i = 1, if_addr_i = 0x100, memory gnt immediately, rvalid next cycle with 0x00000013 → mem_addr_o = 0x100, mem_we_o = 0, mem_be_o = 0xF, if_valid_o pulses 1 cycle with if_rdata_o = 0x13, d_valid_o stays 0.
- Store: d_req_i = 1, d_we_i = 1, d_addr_i = 0x2004, d_wdata_i = 0xDEADBEEF, d_be_i = 0x3, gnt held off 3 cycles → mem_req_o high with stable payload for 4 cycles, then d_valid_o single pulse after rvalid.
- Contention: both requests held continuously, data re-requests immediately after each completion, MAX_STARVE = 4 → grant order D, D, D, D, F, D, D, D, D, F; starve counter returns to 0 after each F.
- Reset asserted in RESP, then rvalid arrives one cycle after reset releases → no valid pulse, state IDLE, busy_o = 0, counter = 0.
- Stray mem_rvalid_i = 1 in IDLE, and mem_gnt_i = 1 in IDLE → no outputs change.
- Fetch drops if_req_i the cycle after latch → transaction completes, if_valid_o still pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the rv32i memory arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface rv32i_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_valid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [BE_W-1:0]   d_be_i;
  logic              d_valid_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_valid_o, if_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output d_valid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_valid_o, if_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  d_valid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// data first, with fetch forced after MAX_STARVE consecutive contended data grants.
module rv32i_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  rv32i_mem_arbiter_if.slave   bus
);
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } payload_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  payload_t            pay_q, pay_d;
  logic                req_q, req_d;
  logic                busy_q;
  logic                grant_data;

  // Next-state, arbitration and payload capture
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    pay_d      = pay_q;
    req_d      = req_q;
    grant_data = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req_i || bus.d_req_i) begin
          grant_data = bus.d_req_i &&
                       !(bus.if_req_i && (starve_q == STARVE_W'(MAX_STARVE)));
          if (grant_data) begin
            owner_d = OWN_DATA;
            pay_d   = '{we: bus.d_we_i, addr: bus.d_addr_i,
                        wdata: bus.d_wdata_i, be: bus.d_be_i};
            if (bus.if_req_i && (starve_q != STARVE_W'(MAX_STARVE)))
              starve_d = starve_q + STARVE_W'(1);
          end else begin
            owner_d  = OWN_FETCH;
            pay_d    = '{we: 1'b0, addr: bus.if_addr_i,
                         wdata: '0, be: '1};
            starve_d = '0;
          end
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          req_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.mem_rvalid_i) state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= IDLE;
      owner_q  <= OWN_FETCH;
      starve_q <= '0;
      pay_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      pay_q    <= pay_d;
      req_q    <= req_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = pay_q.we;
  assign bus.mem_addr_o  = pay_q.addr;
  assign bus.mem_wdata_o = pay_q.wdata;
  assign bus.mem_be_o    = pay_q.be;
  assign bus.busy_o      = busy_q;

  // Response pulses go straight from rvalid to the owning requester
  assign bus.if_valid_o = (state_q == RESP) && bus.mem_rvalid_i && (owner_q == OWN_FETCH);
  assign bus.d_valid_o  = (state_q == RESP) && bus.mem_rvalid_i && (owner_q == OWN_DATA);
  assign bus.if_rdata_o = bus.mem_rdata_i;
  assign bus.d_rdata_o  = bus.mem_rdata_i;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: table of single transactions plus
// hand-written contention, reset, stray-handshake and dropped-request sequences.
module tb_rv32i_mem_arbiter;
  logic clk;
  logic rstn;

  rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
    .clk_i    (clk),
    .resetn_i (rstn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    int          gnt_wait;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_ifv;
    logic        exp_dv;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    bus.if_req_i  = v.if_req;
    bus.if_addr_i = v.if_addr;
    bus.d_req_i   = v.d_req;
    bus.d_we_i    = v.d_we;
    bus.d_addr_i  = v.d_addr;
    bus.d_wdata_i = v.d_wdata;
    bus.d_be_i    = v.d_be;
    @(negedge clk);
    #1;
    chk({v.name, ".req"},   64'(bus.mem_req_o), 64'(1));
    chk({v.name, ".busy"},  64'(bus.busy_o), 64'(1));
    chk({v.name, ".addr"},  64'(bus.mem_addr_o), 64'(v.exp_addr));
    chk({v.name, ".we"},    64'(bus.mem_we_o), 64'(v.exp_we));
    chk({v.name, ".be"},    64'(bus.mem_be_o), 64'(v.exp_be));
    chk({v.name, ".wdata"}, 64'(bus.mem_wdata_o), 64'(v.exp_wdata));
    for (int w = 0; w < v.gnt_wait; w++) begin
      @(negedge clk);
      #1;
      chk({v.name, ".req_hold"},   64'(bus.mem_req_o), 64'(1));
      chk({v.name, ".addr_hold"},  64'(bus.mem_addr_o), 64'(v.exp_addr));
      chk({v.name, ".wdata_hold"}, 64'(bus.mem_wdata_o), 64'(v.exp_wdata));
    end
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = v.rdata;
    #1;
    chk({v.name, ".req_drop"}, 64'(bus.mem_req_o), 64'(0));
    chk({v.name, ".if_valid"}, 64'(bus.if_valid_o), 64'(v.exp_ifv));
    chk({v.name, ".d_valid"},  64'(bus.d_valid_o), 64'(v.exp_dv));
    if (v.exp_ifv) chk({v.name, ".if_rdata"}, 64'(bus.if_rdata_o), 64'(v.rdata));
    if (v.exp_dv)  chk({v.name, ".d_rdata"},  64'(bus.d_rdata_o), 64'(v.rdata));
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk({v.name, ".if_valid_end"}, 64'(bus.if_valid_o), 64'(0));
    chk({v.name, ".d_valid_end"},  64'(bus.d_valid_o), 64'(0));
    chk({v.name, ".busy_end"},     64'(bus.busy_o), 64'(0));
  endtask

  initial begin
    logic pend;
    logic prev_req;
    logic got_d;
    int   grants;
    int   s_exp;

    vecs[0] = '{"fetch",   1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h00000013,
                32'h100,  0, 4'hF, 32'h0,        1, 0};
    vecs[1] = '{"store",   0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 3, 32'h0,
                32'h2004, 1, 4'h3, 32'hDEADBEEF, 0, 1};
    vecs[2] = '{"load",    0, 32'h0,   1, 0, 32'h3000, 32'h0,        4'hF, 1, 32'hCAFEF00D,
                32'h3000, 0, 4'hF, 32'h0,        0, 1};
    vecs[3] = '{"both",    1, 32'h104, 1, 0, 32'h4000, 32'h0,        4'hF, 0, 32'h11223344,
                32'h4000, 0, 4'hF, 32'h0,        0, 1};
    vecs[4] = '{"fetch2",  1, 32'h108, 0, 0, 32'h0,    32'h0,        4'h0, 2, 32'h00500093,
                32'h108,  0, 4'hF, 32'h0,        1, 0};

    rstn = 1'b0;
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_be_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.req",    64'(bus.mem_req_o), 64'(0));
    chk("rst.we",     64'(bus.mem_we_o), 64'(0));
    chk("rst.addr",   64'(bus.mem_addr_o), 64'(0));
    chk("rst.wdata",  64'(bus.mem_wdata_o), 64'(0));
    chk("rst.be",     64'(bus.mem_be_o), 64'(0));
    chk("rst.if_v",   64'(bus.if_valid_o), 64'(0));
    chk("rst.d_v",    64'(bus.d_valid_o), 64'(0));
    chk("rst.busy",   64'(bus.busy_o), 64'(0));
    chk("rst.starve", 64'(dut.starve_q), 64'(0));
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);
    chk("table.starve", 64'(dut.starve_q), 64'(0));

    // Contention with a zero-wait memory: expect D,D,D,D,F,D,D,D,D,F
    @(negedge clk);
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h2000; bus.d_be_i = 4'hF;
    pend = 0; prev_req = 0; grants = 0; s_exp = 0;
    for (int c = 0; c < 80 && grants < 10; c++) begin
      @(negedge clk);
      bus.mem_rvalid_i = pend;
      bus.mem_rdata_i  = 32'hA5A5_0000 + 32'(c);
      pend             = bus.mem_req_o;
      bus.mem_gnt_i    = bus.mem_req_o;
      #1;
      if (bus.mem_req_o && !prev_req) begin
        got_d = (bus.mem_addr_o == 32'h2000);
        chk($sformatf("contend.owner%0d", grants), 64'(got_d), 64'(exp_order[grants]));
        s_exp = exp_order[grants] ? ((s_exp == 4) ? 4 : s_exp + 1) : 0;
        chk($sformatf("contend.starve%0d", grants), 64'(dut.starve_q), 64'(s_exp));
        grants++;
      end
      prev_req = bus.mem_req_o;
    end
    chk("contend.grants", 64'(grants), 64'(10));
    bus.if_req_i = 0; bus.d_req_i = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mem_rvalid_i = pend;
      pend             = bus.mem_req_o;
      bus.mem_gnt_i    = bus.mem_req_o;
    end
    bus.mem_rvalid_i = 0; bus.mem_gnt_i = 0;
    #1;
    chk("contend.busy_end", 64'(bus.busy_o), 64'(0));
    chk("contend.starve_end", 64'(dut.starve_q), 64'(0));

    // Reset while waiting for the response abandons the transaction
    @(negedge clk);
    bus.if_req_i = 1; bus.if_addr_i = 32'h200;
    @(negedge clk);
    bus.mem_gnt_i = 1;
    @(negedge clk);
    bus.mem_gnt_i = 0; bus.if_req_i = 0; rstn = 0;
    @(negedge clk);
    #1;
    chk("rresp.busy", 64'(bus.busy_o), 64'(0));
    chk("rresp.req",  64'(bus.mem_req_o), 64'(0));
    rstn = 1;
    @(negedge clk);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h55;
    #1;
    chk("rresp.if_v",   64'(bus.if_valid_o), 64'(0));
    chk("rresp.d_v",    64'(bus.d_valid_o), 64'(0));
    chk("rresp.starve", 64'(dut.starve_q), 64'(0));
    chk("rresp.addr",   64'(bus.mem_addr_o), 64'(0));
    @(negedge clk);
    bus.mem_rvalid_i = 0;
    #1;
    chk("rresp.busy2", 64'(bus.busy_o), 64'(0));

    // Stray gnt/rvalid in IDLE
    @(negedge clk);
    bus.mem_rvalid_i = 1; bus.mem_gnt_i = 1;
    #1;
    chk("stray.if_v", 64'(bus.if_valid_o), 64'(0));
    chk("stray.d_v",  64'(bus.d_valid_o), 64'(0));
    @(negedge clk);
    #1;
    chk("stray.req",  64'(bus.mem_req_o), 64'(0));
    chk("stray.busy", 64'(bus.busy_o), 64'(0));
    chk("stray.addr", 64'(bus.mem_addr_o), 64'(0));
    chk("stray.we",   64'(bus.mem_we_o), 64'(0));
    chk("stray.if_v2", 64'(bus.if_valid_o), 64'(0));
    bus.mem_rvalid_i = 0; bus.mem_gnt_i = 0;

    // Fetch request dropped and address changed after latch
    @(negedge clk);
    bus.if_req_i = 1; bus.if_addr_i = 32'h300;
    @(negedge clk);
    #1;
    chk("drop.req",  64'(bus.mem_req_o), 64'(1));
    chk("drop.addr", 64'(bus.mem_addr_o), 64'(32'h300));
    bus.if_req_i = 0; bus.if_addr_i = 32'h999;
    @(negedge clk);
    #1;
    chk("drop.req2",  64'(bus.mem_req_o), 64'(1));
    chk("drop.addr2", 64'(bus.mem_addr_o), 64'(32'h300));
    bus.mem_gnt_i = 1;
    @(negedge clk);
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234;
    #1;
    chk("drop.if_v",     64'(bus.if_valid_o), 64'(1));
    chk("drop.if_rdata", 64'(bus.if_rdata_o), 64'(32'h1234));
    chk("drop.d_v",      64'(bus.d_valid_o), 64'(0));
    @(negedge clk);
    bus.mem_rvalid_i = 0;
    #1;
    chk("drop.if_v_end", 64'(bus.if_valid_o), 64'(0));
    chk("drop.busy_end", 64'(bus.busy_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
